oh_memory_bist: RTL and testbench

//  March C- built-in self-test controller for one single-port SRAM instance.

---
 rtl/oh_memory_bist.sv | 157 +++++++++++++++
 tb/tb_oh_memory_bist.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oh_memory_bist.sv
// March C- self-test controller for one single-port SRAM.
// Drives the memory's bist_* port, checks read data one cycle later and latches the first mismatch.
module oh_memory_bist #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          bist_en,
  output logic          bist_we,
  output logic [DW-1:0] bist_wem,
  output logic [AW-1:0] bist_addr,
  output logic [DW-1:0] bist_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem
);

  localparam int unsigned EW = 3;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [EW-1:0] elem;

  logic          chk_valid;
  logic [DW-1:0] chk_exp;
  logic [AW-1:0] chk_addr;
  logic [EW-1:0] chk_elem;

  logic [EW-1:0] nxt_elem;
  logic [AW-1:0] nxt_addr;
  logic          nxt_rd;
  logic          run_end;

  // Next march access; the registered bist_we tells read vs write phase of a two-op element.
  always_comb begin
    nxt_elem = elem;
    nxt_addr = bist_addr;
    nxt_rd   = 1'b1;
    run_end  = 1'b0;
    case (elem)
      3'd0: begin
        if (bist_addr == LAST) begin
          nxt_elem = 3'd1;
          nxt_addr = '0;
        end else begin
          nxt_addr = AW'(bist_addr + AW'(1));
          nxt_rd   = 1'b0;
        end
      end
      3'd1, 3'd2: begin
        if (!bist_we) begin
          nxt_rd = 1'b0;
        end else if (bist_addr == LAST) begin
          nxt_elem = EW'(elem + EW'(1));
          nxt_addr = (elem == 3'd2) ? LAST : '0;
        end else begin
          nxt_addr = AW'(bist_addr + AW'(1));
        end
      end
      3'd3, 3'd4: begin
        if (!bist_we) begin
          nxt_rd = 1'b0;
        end else if (bist_addr == '0) begin
          nxt_elem = EW'(elem + EW'(1));
          nxt_addr = LAST;
        end else begin
          nxt_addr = AW'(bist_addr - AW'(1));
        end
      end
      default: begin
        if (bist_addr == '0) run_end = 1'b1;
        else                 nxt_addr = AW'(bist_addr - AW'(1));
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      elem      <= '0;
      bist_en   <= 1'b0;
      bist_we   <= 1'b0;
      bist_wem  <= '0;
      bist_addr <= '0;
      bist_din  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      chk_valid <= 1'b0;
      chk_exp   <= '0;
      chk_addr  <= '0;
      chk_elem  <= '0;
    end else begin
      done      <= 1'b0;
      // Odd elements read zeros, even elements read ones.
      chk_valid <= bist_en & ~bist_we;
      chk_exp   <= {DW{~elem[0]}};
      chk_addr  <= bist_addr;
      chk_elem  <= elem;
      if (chk_valid && (mem_dout != chk_exp) && !fail) begin
        fail      <= 1'b1;
        fail_addr <= chk_addr;
        fail_elem <= chk_elem;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            elem      <= '0;
            bist_en   <= 1'b1;
            bist_we   <= 1'b1;
            bist_wem  <= '1;
            bist_addr <= '0;
            bist_din  <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
          end
        end
        RUN: begin
          if (run_end) begin
            state     <= DRAIN;
            bist_en   <= 1'b0;
            bist_we   <= 1'b0;
            bist_wem  <= '0;
            bist_addr <= '0;
            bist_din  <= '0;
          end else begin
            elem      <= nxt_elem;
            bist_addr <= nxt_addr;
            bist_we   <= ~nxt_rd;
            bist_wem  <= {DW{~nxt_rd}};
            bist_din  <= {DW{~nxt_rd & nxt_elem[0]}};
          end
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oh_memory_bist.sv
// Self-checking bench for oh_memory_bist: DEPTH=4 and DEPTH=5 instances, each beside an 8-bit RAM model with injectable faults.
module tb_oh_memory_bist;

  typedef struct packed {
    logic        we;
    logic [7:0]  wem;
    logic [31:0] addr;
    logic [7:0]  din;
  } acc_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start4 = 1'b0;
  logic start5 = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fault_mode = 0;  // 0 none, 1 addr2 bit0 stuck-at-1, 2 write-1 to addr1 couples into addr2

  acc_t exp_q[$];
  acc_t obs_q[$];

  logic       en4, we4, busy4, done4, fail4;
  logic [7:0] wem4, din4, dout4;
  logic [1:0] addr4, faddr4;
  logic [2:0] felem4;
  logic       en5, we5, busy5, done5, fail5;
  logic [7:0] wem5, din5, dout5;
  logic [2:0] addr5, faddr5;
  logic [2:0] felem5;

  logic [7:0] mem4 [4];
  logic [7:0] mem5 [5];

  oh_memory_bist #(.DW(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .bist_en(en4), .bist_we(we4), .bist_wem(wem4), .bist_addr(addr4), .bist_din(din4),
    .mem_dout(dout4), .busy(busy4), .done(done4), .fail(fail4),
    .fail_addr(faddr4), .fail_elem(felem4)
  );

  oh_memory_bist #(.DW(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start5),
    .bist_en(en5), .bist_we(we5), .bist_wem(wem5), .bist_addr(addr5), .bist_din(din5),
    .mem_dout(dout5), .busy(busy5), .done(done5), .fail(fail5),
    .fail_addr(faddr5), .fail_elem(felem5)
  );

  always @(posedge clk) begin
    if (en4) begin
      if (we4) begin
        mem4[addr4] <= (mem4[addr4] & ~wem4) | (din4 & wem4);
        if (fault_mode == 2 && addr4 == 2'd1 && din4 == 8'hFF) mem4[2] <= 8'hFF;
      end else begin
        dout4 <= (fault_mode == 1 && addr4 == 2'd2) ? (mem4[addr4] | 8'h01) : mem4[addr4];
      end
    end
  end

  always @(posedge clk) begin
    if (en5) begin
      if (we5) mem5[addr5] <= (mem5[addr5] & ~wem5) | (din5 & wem5);
      else     dout5 <= mem5[addr5];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference March C- access list, expanded element by element.
  task automatic build_march(input int depth);
    acc_t a;
    exp_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < depth; k++) begin
        a.addr = (e < 3) ? 32'(k) : 32'(depth - 1 - k);
        if (e != 0) begin
          a.we = 1'b0; a.wem = 8'h00; a.din = 8'h00;
          exp_q.push_back(a);
        end
        if (e != 5) begin
          a.we = 1'b1; a.wem = 8'hFF;
          a.din = (e == 1 || e == 3) ? 8'hFF : 8'h00;
          exp_q.push_back(a);
        end
      end
    end
  endtask

  // Start one run and record accesses, busy cycles and done pulses (stimulus/monitor only).
  task automatic run_dut(input int sel, input bit hold, output int busy_n, output int done_n,
                         output int max_addr);
    acc_t a;
    logic en, b, d;
    obs_q.delete();
    busy_n = 0; done_n = 0; max_addr = 0;
    @(negedge clk);
    if (sel == 4) start4 = 1'b1; else start5 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!hold) begin start4 = 1'b0; start5 = 1'b0; end
      if (sel == 4) begin
        en = en4; b = busy4; d = done4;
        a.we = we4; a.wem = wem4; a.addr = 32'(addr4); a.din = din4;
      end else begin
        en = en5; b = busy5; d = done5;
        a.we = we5; a.wem = wem5; a.addr = 32'(addr5); a.din = din5;
      end
      if (b) busy_n++;
      if (en) begin
        obs_q.push_back(a);
        if (int'(a.addr) > max_addr) max_addr = int'(a.addr);
      end
      if (d) begin
        done_n++;
        start4 = 1'b0; start5 = 1'b0;
        break;
      end
    end
    start4 = 1'b0; start5 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (sel == 4) begin if (done4) done_n++; if (busy4) busy_n++; end
      else          begin if (done5) done_n++; if (busy5) busy_n++; end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({en4, we4, wem4, addr4, din4, busy4, done4, fail4, faddr4, felem4} !== '0) begin
      failures++;
      $display("FAIL reset_outputs4: got %h required 0",
               {en4, we4, wem4, addr4, din4, busy4, done4, fail4, faddr4, felem4});
    end
    checks++;
    if ({en5, we5, wem5, addr5, din5, busy5, done5, fail5, faddr5, felem5} !== '0) begin
      failures++;
      $display("FAIL reset_outputs5: got %h required 0",
               {en5, we5, wem5, addr5, din5, busy5, done5, fail5, faddr5, felem5});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({en4, busy4, done4} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: got %b required 000", {en4, busy4, done4});
    end
  endtask

  task automatic test_clean();
    int bn, dn, ma;
    acc_t e, o;
    fault_mode = 0;
    build_march(4);
    run_dut(4, 1'b0, bn, dn, ma);
    checks++;
    if (bn !== 41) begin failures++; $display("FAIL clean_busy: got %0d required 41", bn); end
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL clean_done: got %0d required 1", dn); end
    checks++;
    if (fail4 !== 1'b0) begin failures++; $display("FAIL clean_fail: got %b required 0", fail4); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL clean_access_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL clean_access[%0d]: got we=%b wem=%h addr=%0d din=%h required we=%b wem=%h addr=%0d din=%h",
                 i, o.we, o.wem, o.addr, o.din, e.we, e.wem, e.addr, e.din);
      end
    end
  endtask

  task automatic test_stuck_at();
    int bn, dn, ma;
    fault_mode = 1;
    run_dut(4, 1'b0, bn, dn, ma);
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL stuck_done: got %0d required 1", dn); end
    checks++;
    if ({fail4, faddr4, felem4} !== {1'b1, 2'd2, 3'd1}) begin
      failures++;
      $display("FAIL stuck_result: got fail=%b addr=%0d elem=%0d required fail=1 addr=2 elem=1",
               fail4, faddr4, felem4);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({fail4, faddr4, felem4} !== {1'b1, 2'd2, 3'd1}) begin
      failures++;
      $display("FAIL stuck_hold_idle: got fail=%b addr=%0d elem=%0d required fail=1 addr=2 elem=1",
               fail4, faddr4, felem4);
    end
  endtask

  task automatic test_mid_reset();
    int bn, dn, ma;
    fault_mode = 0;
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy4 !== 1'b1) begin failures++; $display("FAIL midrun_busy: got %b required 1", busy4); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({en4, we4, wem4, addr4, din4, busy4, done4, fail4, faddr4, felem4} !== '0) begin
      failures++;
      $display("FAIL midrun_reset_outputs: got %h required 0",
               {en4, we4, wem4, addr4, din4, busy4, done4, fail4, faddr4, felem4});
    end
    @(negedge clk) reset = 1'b0;
    run_dut(4, 1'b0, bn, dn, ma);
    checks++;
    if ({bn, dn} !== {32'd41, 32'd1}) begin
      failures++;
      $display("FAIL after_reset_run: got busy=%0d done=%0d required busy=41 done=1", bn, dn);
    end
    checks++;
    if (fail4 !== 1'b0) begin failures++; $display("FAIL after_reset_fail: got %b required 0", fail4); end
  endtask

  task automatic test_coupling();
    int bn, dn, ma;
    fault_mode = 2;
    run_dut(4, 1'b0, bn, dn, ma);
    checks++;
    if ({fail4, faddr4, felem4} !== {1'b1, 2'd2, 3'd1}) begin
      failures++;
      $display("FAIL coupling_result: got fail=%b addr=%0d elem=%0d required fail=1 addr=2 elem=1",
               fail4, faddr4, felem4);
    end
  endtask

  task automatic test_start_held();
    int bn, dn, ma;
    fault_mode = 0;
    run_dut(4, 1'b1, bn, dn, ma);
    checks++;
    if (bn !== 41) begin failures++; $display("FAIL held_busy: got %0d required 41", bn); end
    checks++;
    if (dn !== 1) begin failures++; $display("FAIL held_done: got %0d required 1", dn); end
    checks++;
    if ({fail4, faddr4, felem4} !== '0) begin
      failures++;
      $display("FAIL held_fail_cleared: got fail=%b addr=%0d elem=%0d required 0 0 0",
               fail4, faddr4, felem4);
    end
  endtask

  task automatic test_depth5();
    int bn, dn, ma;
    acc_t e, o;
    build_march(5);
    run_dut(5, 1'b0, bn, dn, ma);
    checks++;
    if (bn !== 51) begin failures++; $display("FAIL d5_busy: got %0d required 51", bn); end
    checks++;
    if (ma !== 4) begin failures++; $display("FAIL d5_max_addr: got %0d required 4", ma); end
    checks++;
    if ({fail5, dn} !== {1'b0, 32'd1}) begin
      failures++;
      $display("FAIL d5_result: got fail=%b done=%0d required fail=0 done=1", fail5, dn);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL d5_access_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL d5_access[%0d]: got we=%b addr=%0d din=%h required we=%b addr=%0d din=%h",
                 i, o.we, o.addr, o.din, e.we, e.addr, e.din);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck_at();
    test_mid_reset();
    test_coupling();
    test_start_held();
    test_depth5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
